// File: rtl/ll_dequeue_arbiter_pkg.sv
// Shared definitions for the linked-list dequeue arbiter and its pointer manager.
// Holds the FSM encoding and the index-width helpers both blocks size their ports with.
package ll_dequeue_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  function automatic int ptr_width(input int elems);
    return (elems > 1) ? $clog2(elems) : 1;
  endfunction

  function automatic int id_width(input int lists);
    return (lists > 1) ? $clog2(lists) : 1;
  endfunction

endpackage

// File: rtl/ll_dequeue_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after index 'last',
// wrapping modulo NUM_LISTS (which need not be a power of two).
module rr_arbiter
  import ll_dequeue_arbiter_pkg::*;
#(
  parameter int NUM_LISTS = 2,
  parameter int ID_WIDTH  = id_width(NUM_LISTS)
) (
  input  logic [NUM_LISTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  last,
  output logic [NUM_LISTS-1:0] grant_onehot,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic                 any_grant
);

  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    any_grant    = 1'b0;
    // Candidate order is last+1, last+2, ...; j only ever indexes req with a loop constant.
    for (int k = 1; k <= NUM_LISTS; k++) begin
      for (int j = 0; j < NUM_LISTS; j++) begin
        if (!any_grant && req[j] && (j == ((int'(last) + k) % NUM_LISTS))) begin
          any_grant       = 1'b1;
          grant_onehot[j] = 1'b1;
          grant_id        = ID_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ll_dequeue_arbiter.sv
// Read-side companion to the shared-memory linked-list manager: picks a non-empty list
// round-robin, pops it, reads the head word from the data RAM and presents it valid/ready.
module ll_dequeue_arbiter
  import ll_dequeue_arbiter_pkg::*;
#(
  parameter int NUM_ELEMS  = 4,
  parameter int NUM_LISTS  = 2,
  parameter int PTR_WIDTH  = ptr_width(NUM_ELEMS),
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = id_width(NUM_LISTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_LISTS-1:0]           empty,
  input  logic [NUM_LISTS*PTR_WIDTH-1:0] head,
  output logic [NUM_LISTS-1:0]           pop,
  output logic                           rd_en,
  output logic [PTR_WIDTH-1:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [ID_WIDTH-1:0]            out_id
);

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   rr_last, id_q;
  logic [NUM_LISTS-1:0]  eligible, grant_onehot;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  any_grant, issue;
  logic [PTR_WIDTH-1:0]  head_sel;

  assign eligible = en ? ~empty : '0;

  rr_arbiter #(
    .NUM_LISTS (NUM_LISTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_rr (
    .req          (eligible),
    .last         (rr_last),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .any_grant    (any_grant)
  );

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      if (grant_onehot[i]) head_sel = head_sel | head[PTR_WIDTH*i +: PTR_WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_grant) begin
          issue      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      // empty is not trusted here: the manager's count lags the pop by a cycle.
      ST_FETCH: state_next = ST_VALID;
      ST_VALID: begin
        if (out_ready) begin
          if (any_grant) begin
            issue      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Keep pop/rd_en quiet while reset is held, even though state already reads IDLE.
    if (rst) issue = 1'b0;
  end

  assign pop       = issue ? grant_onehot : '0;
  assign rd_en     = issue;
  assign rd_addr   = issue ? head_sel : '0;
  assign out_valid = (state == ST_VALID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last  <= ID_WIDTH'(NUM_LISTS - 1);
      id_q     <= '0;
      out_data <= '0;
      out_id   <= '0;
    end else begin
      if (issue) begin
        id_q    <= grant_id;
        rr_last <= grant_id;
      end
      if (state == ST_FETCH) begin
        out_data <= rd_data;
        out_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_ll_dequeue_arbiter.sv
// Bench for ll_dequeue_arbiter: queue-based list/RAM environment plus an occupancy-level
// reference model (in-flight word, pending output word, last-granted list).
module tb_ll_dequeue_arbiter;
  localparam int N  = 2;
  localparam int E  = 4;
  localparam int PW = 2;
  localparam int DW = 8;
  localparam int IW = 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  empty;
  logic [N*PW-1:0] head;
  logic [N-1:0]  pop;
  logic          rd_en;
  logic [PW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;

  ll_dequeue_arbiter #(
    .NUM_ELEMS(E), .NUM_LISTS(N), .PTR_WIDTH(PW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .empty(empty), .head(head), .pop(pop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment: lists as queues of node pointers over a shared memory
  logic [PW-1:0] lq[N][$];
  logic [PW-1:0] free_q[$];
  logic [DW-1:0] mem[E];
  int remaining[N];
  bit feed_rand;

  // reference model state
  int rr;
  bit inflight;
  int infl_id;
  logic [DW-1:0] infl_data;
  bit pending;
  logic [DW-1:0] pend_data;
  int pend_id;

  // samples from the last negedge
  logic [N-1:0]  s_pop;
  logic          s_rd_en;
  logic [PW-1:0] s_rd_addr;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [IW-1:0] s_id;
  bit            s_accept;

  int compared;
  int mismatched;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_winner();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (rr + k) % N;
      if (en && lq[j].size() != 0) return j;
    end
    return -1;
  endfunction

  task automatic add_word(input int l, input logic [DW-1:0] d);
    logic [PW-1:0] n;
    if (free_q.size() == 0) return;
    n = free_q.pop_front();
    mem[n] = d;
    lq[l].push_back(n);
  endtask

  task automatic drive_lists();
    for (int i = 0; i < N; i++) begin
      empty[i] = (lq[i].size() == 0);
      head[i*PW +: PW] = (lq[i].size() != 0) ? lq[i][0] : '0;
    end
  endtask

  task automatic cycle();
    int w;
    bit issue;
    logic [DW-1:0] nd;
    drive_lists();
    @(negedge clk);
    w = ref_winner();
    issue = !rst && !inflight && (!pending || out_ready) && (w >= 0);
    nd = issue ? mem[lq[w][0]] : '0;
    s_pop = pop; s_rd_en = rd_en; s_rd_addr = rd_addr;
    s_valid = out_valid; s_data = out_data; s_id = out_id;
    s_accept = out_valid && out_ready;
    chk("pop", pop, issue ? (32'd1 << w) : 32'd0);
    chk("pop_onehot0", $onehot0(pop), 1);
    chk("rd_en", rd_en, issue);
    if (issue) chk("rd_addr", rd_addr, lq[w][0]);
    chk("out_valid", out_valid, pending);
    if (pending) begin
      chk("out_data", out_data, pend_data);
      chk("out_id", out_id, pend_id);
    end
    @(posedge clk);
    #1;
    if (pending && out_ready) pending = 0;
    if (inflight) begin
      pending = 1; pend_data = infl_data; pend_id = infl_id; inflight = 0;
    end
    if (issue) begin
      inflight = 1; infl_id = w; infl_data = nd; rr = w;
    end
    rd_data = s_rd_en ? mem[s_rd_addr] : DW'($urandom);
    for (int i = 0; i < N; i++)
      if (s_pop[i] && lq[i].size() != 0) free_q.push_back(lq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (remaining[i] > 0 && free_q.size() != 0 && (!feed_rand || $urandom_range(1, 0) == 1)) begin
        add_word(i, DW'($urandom));
        remaining[i]--;
      end
    end
  endtask

  task automatic wait_pop(input string tag);
    for (int n = 0; n < 30; n++) begin
      cycle();
      if (s_pop != 0) break;
    end
    chk(tag, s_pop != 0, 1);
  endtask

  // Async pulse between edges, then a manager reset at release and a fresh grant check.
  task automatic rst_test(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_pop_drop"}, pop, 0);
    chk({tag, "_rd_en_drop"}, rd_en, 0);
    chk({tag, "_data_clr"}, out_data, 0);
    chk({tag, "_id_clr"}, out_id, 0);
    inflight = 0; pending = 0; rr = N - 1;
    remaining[0] = 0; remaining[1] = 0;
    cycle();
    for (int i = 0; i < N; i++) lq[i].delete();
    free_q = '{0, 1, 2, 3};
    add_word(0, 8'h3C);
    add_word(1, 8'hC3);
    rst = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk({tag, "_grant0_first"}, s_pop, 2'b01);
  endtask

  initial begin
    int delivered, pops, deliv;
    logic [DW-1:0] held_d;
    logic [IW-1:0] held_id;
    compared = 0; mismatched = 0;
    rst = 1'b1; en = 1'b1; out_ready = 1'b0; rd_data = '0;
    empty = '1; head = '0;
    free_q = '{3, 0, 1, 2};
    rr = N - 1; inflight = 0; pending = 0; feed_rand = 0;
    remaining[0] = 0; remaining[1] = 0;

    // reset release with all lists empty
    cycle(); cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("idle_out_data", s_data, 0);
      chk("idle_out_id", s_id, 0);
      chk("idle_rd_addr", s_rd_addr, 0);
    end

    // single word on list 0, head node 3
    add_word(0, 8'hA5);
    out_ready = 1'b1;
    cycle();
    chk("dir_pop", s_pop, 2'b01);
    chk("dir_rd_addr", s_rd_addr, 3);
    cycle();
    chk("dir_fetch_not_valid", s_valid, 0);
    cycle();
    chk("dir_valid", s_valid, 1);
    chk("dir_data", s_data, 8'hA5);
    chk("dir_id", s_id, 0);

    // both lists, three words each, consumer always ready
    remaining[0] = 3; remaining[1] = 3;
    delivered = 0;
    for (int c = 0; c < 40 && delivered < 6; c++) begin
      cycle();
      if (s_accept) delivered++;
    end
    chk("rr_six_words", delivered, 6);

    // consumer stalls while a word is valid
    out_ready = 1'b0;
    remaining[0] = 2; remaining[1] = 2;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (s_valid) break;
    end
    chk("stall_reach_valid", s_valid, 1);
    held_d = s_data; held_id = s_id;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("stall_data", s_data, held_d);
      chk("stall_id", s_id, held_id);
      chk("stall_no_pop", s_pop, 0);
    end
    out_ready = 1'b1;
    cycle();
    chk("stall_issue_on_ready", s_pop != 0, 1);

    // en dropped during FETCH
    remaining[0] = 2; remaining[1] = 2;
    wait_pop("en_wait_pop");
    en = 1'b0;
    pops = 0; deliv = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (s_pop != 0) pops++;
      if (s_accept) deliv++;
    end
    chk("en0_no_pop", pops, 0);
    chk("en0_word_delivered", deliv, 1);
    if (lq[0].size() == 0 && lq[1].size() == 0) add_word(0, 8'h5A);
    en = 1'b1;
    cycle();
    chk("en_resume", s_pop != 0, 1);

    // reset mid-FETCH, then mid-VALID
    remaining[0] = 2; remaining[1] = 2;
    wait_pop("rst_fetch_wait_pop");
    rst_test("rst_fetch");
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (s_valid) break;
    end
    chk("rst_valid_reach_valid", s_valid, 1);
    rst_test("rst_valid");

    // randomized traffic
    feed_rand = 1;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(9, 0) != 0);
      out_ready = $urandom_range(1, 0);
      if ($urandom_range(7, 0) == 0) begin
        remaining[0] += $urandom_range(2, 0);
        remaining[1] += $urandom_range(2, 0);
      end
      cycle();
    end
    en = 1'b1; out_ready = 1'b1; remaining[0] = 0; remaining[1] = 0;
    for (int c = 0; c < 20; c++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ll_dequeue_arbiter.md
Name: ll_dequeue_arbiter

Overview:
- Read-side companion to the N-list shared-memory linked-list pointer manager.
- Each dequeue proceeds as follows:
  - Selects a non-empty list by round-robin.
  - Issues a one-hot pop to the manager.
  - Reads the payload word at that list's head pointer from the shared data RAM (1-cycle read latency).
  - Presents the word with its list id on a valid/ready output.
- Sits between the pointer manager and the data RAM on one side and the downstream consumer on the other.

Parameters:
- NUM_ELEMS, 4, nodes in shared memory
- NUM_LISTS, 2, number of lists
- PTR_WIDTH, $clog2(NUM_ELEMS), node pointer width
- DATA_WIDTH, 8, payload word width
- ID_WIDTH, (NUM_LISTS>1 ? $clog2(NUM_LISTS) : 1), list index width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  1 = new dequeues may start; 0 = in-flight dequeue completes, no new pop issued
- empty  input  NUM_LISTS  bit i = 1 when list i is empty (from pointer manager)
- head  input  NUM_LISTS*PTR_WIDTH  packed head pointers, list i at [PTR_WIDTH*i +: PTR_WIDTH]
- pop  output  NUM_LISTS  zero or one-hot pop to pointer manager
- rd_en  output  1  data RAM read strobe
- rd_addr  output  PTR_WIDTH  data RAM read address
- rd_data  input  DATA_WIDTH  data RAM read data, valid the cycle after rd_en
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts the word
- out_data  output  DATA_WIDTH  dequeued payload
- out_id  output  ID_WIDTH  list the payload came from

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pop=0; rd_en=0; rd_addr=0; out_valid=0; out_data=0; out_id=0.
  - rr_last=NUM_LISTS-1, so list 0 has first priority.
- Selection:
  - eligible = ~empty masked by en.
  - The winner is the first eligible index scanning rr_last+1, rr_last+2, … modulo NUM_LISTS.
  - Wrap-around is modulo NUM_LISTS, not a power of 2.
- pop, rd_en and rd_addr are combinational decodes of the "issue" condition in the current cycle:
  - pop = onehot(winner).
  - rd_en = 1.
  - rd_addr = head[winner].
  - The address is sampled by the RAM at the same edge at which the manager advances its head.
- FSM:
  - IDLE: if any eligible -> issue; capture winner into id_q and rr_last; go FETCH. Otherwise stay.
  - FETCH:
    - pop=0, rd_en=0.
    - Capture rd_data into out_data and id_q into out_id at the clock edge; go VALID.
    - The empty input is ignored in FETCH because the manager's count lags the pop by one cycle.
  - VALID: out_valid=1; out_data and out_id held stable.
    - out_ready=1 and any eligible -> issue the next dequeue in the same cycle; go FETCH.
    - out_ready=1, none eligible -> IDLE.
    - out_ready=0 -> stay, with pop=0.
- Throughput: 1 word per 2 cycles. Latency from a list becoming non-empty in IDLE to out_valid: 2 cycles.
- At most one pop per cycle; never pop a list whose empty=1; never two pops on the same list less than 2 cycles apart.
- en deasserted mid-operation: FETCH/VALID complete normally; no new issue.
- out_valid never drops without a handshake, except on reset.
- Reset mid-operation aborts the dequeue. The popped word is lost, which is acceptable because the manager resets at the same time.
- All lists empty: idle indefinitely with pop=0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/FETCH/VALID, 2 bits);
  - the ID_WIDTH/PTR_WIDTH derivation constants, shared with the pointer manager.
- One sub-module: rr_arbiter. Inputs are req[NUM_LISTS] and last[ID_WIDTH]; outputs are grant_onehot, grant_id and any_grant; it is purely combinational.
- FSM, head mux and output registers stay in the top.

Test Plan:
- Reset release with empty=2'b11, en=1 -> pop=0 and out_valid=0 for 10 cycles; all outputs 0.
- empty=2'b10, head={2'd0,2'd3}, rd_data=8'hA5 the next cycle:
  - pop=2'b01 and rd_addr=3 in cycle 0;
  - out_valid=1, out_data=8'hA5, out_id=0 from cycle 2.
- Both lists non-empty, out_ready=1, 3 words each -> out_id sequence 0,1,0,1,0,1; a pop every 2nd cycle; never two bits of pop set.
- out_ready=0 for 5 cycles while VALID -> out_data/out_id stable, pop=0; on ready, the next pop is issued the same cycle.
- en=0 asserted during FETCH -> the word is still delivered; no further pop while en=0; dequeuing resumes one cycle after en=1.
- Async rst pulse mid-FETCH (between edges) -> out_valid, pop and rd_en drop immediately; after release, list 0 is granted first.
